// File: rtl/fp_requant_pkg.sv
// fp_requant_pkg: shared definitions for the fixed-point requantiser.
//   - rounding mode encodings used on i_mode
//   - sat_limits(): signed min/max representable in a WI_OUT.WF_OUT word
package fp_requant_pkg;

    localparam logic [1:0] RND_FLOOR     = 2'b00;
    localparam logic [1:0] RND_HALF_UP   = 2'b01;
    localparam logic [1:0] RND_HALF_EVEN = 2'b10;
    localparam logic [1:0] RND_TO_ZERO   = 2'b11;

    typedef struct packed {
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
    } sat_lim_t;

    // Limits of a signed word of wi_out+wf_out bits, in units of its LSB.
    function automatic sat_lim_t sat_limits(input int wi_out, input int wf_out);
        sat_lim_t lim;
        lim.max_v = (64'sd1 <<< (wi_out + wf_out - 1)) - 64'sd1;
        lim.min_v = -(64'sd1 <<< (wi_out + wf_out - 1));
        return lim;
    endfunction

endpackage

// File: rtl/fp_round_incr.sv
// fp_round_incr: combinational rounding-increment decision.
//   D        number of discarded fraction bits (0 = identity, never increments)
//   i_q_lsb  LSB of the floor-shifted value (tie-break for HALF_EVEN)
//   i_r      discarded remainder bits
//   i_sign   sign of the original sample
//   i_mode   rounding mode (fp_requant_pkg RND_*)
//   o_inc    1 when the floor result must be incremented
module fp_round_incr
    import fp_requant_pkg::*;
#(
    parameter  int D  = 14,
    localparam int RW = (D > 0) ? D : 1
) (
    input  logic          i_q_lsb,
    input  logic [RW-1:0] i_r,
    input  logic          i_sign,
    input  logic [1:0]    i_mode,
    output logic          o_inc
);

    generate
        if (D == 0) begin : g_identity
            assign o_inc = 1'b0;
        end else begin : g_round
            // Remainder value of exactly one half output LSB.
            localparam logic [RW-1:0] HALF = RW'(1'b1) << (D - 1);

            // Increment decision per rounding mode.
            always_comb begin
                o_inc = 1'b0;
                case (i_mode)
                    RND_FLOOR:     o_inc = 1'b0;
                    RND_HALF_UP:   o_inc = (i_r >= HALF);
                    RND_HALF_EVEN: o_inc = (i_r > HALF) || ((i_r == HALF) && i_q_lsb);
                    // floor already rounds positives toward zero; negatives with
                    // a non-zero remainder need one step back up
                    RND_TO_ZERO:   o_inc = i_sign && (i_r != {RW{1'b0}});
                    default:       o_inc = 1'b0;
                endcase
            end
        end
    endgenerate

endmodule

// File: rtl/fp_requant_pipe.sv
// fp_requant_pipe: two-stage pipelined signed fixed-point requantiser,
// WI_IN.WF_IN -> WI_OUT.WF_OUT, run-time rounding mode, valid/ready on both sides.
//   Stage S1: floor shift + rounding increment, full-width sum q+inc.
//   Stage S2: range check, wrap or saturate, overflow flag.
// Build option: define FP_REQUANT_SAT_EN to clamp overflowing results to the
// output range; otherwise the low output bits of q+inc are kept (wrap).
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_mode             rounding mode, sampled with each accepted input
//   i_in_valid/o_in_ready/i_in_data     input stream
//   o_out_valid/i_out_ready/o_out_data  output stream
//   o_out_ovf          this output sample was out of range
//   o_ovf_count        overflowed output transfers since reset, saturating
module fp_requant_pipe
    import fp_requant_pkg::*;
#(
    parameter int WI_IN  = 4,
    parameter int WF_IN  = 28,
    parameter int WI_OUT = 2,
    parameter int WF_OUT = 14,
    parameter int CNT_W  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [1:0]                i_mode,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic [WI_IN+WF_IN-1:0]    i_in_data,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [WI_OUT+WF_OUT-1:0]  o_out_data,
    output logic                      o_out_ovf,
    output logic [CNT_W-1:0]          o_ovf_count
);

    localparam int D  = WF_IN - WF_OUT;
    localparam int IW = WI_IN + WF_IN;
    localparam int QW = WI_IN + WF_OUT;
    localparam int SW = QW + 1;          // q+inc can exceed q by one LSB
    localparam int W  = WI_OUT + WF_OUT;
    localparam int RW = (D > 0) ? D : 1;

    localparam sat_lim_t              LIM   = sat_limits(WI_OUT, WF_OUT);
    localparam logic signed [SW-1:0]  MAX_V = SW'(LIM.max_v);
    localparam logic signed [SW-1:0]  MIN_V = SW'(LIM.min_v);

    logic signed [QW-1:0] w_q;
    logic [RW-1:0]        w_r;
    logic                 w_inc;
    logic signed [SW-1:0] w_sum;
    logic                 w_s2_free;
    logic                 w_ovf;
    logic [W-1:0]         w_res;

    logic                 r_s1_v;
    logic signed [SW-1:0] r_s1_sum;
    logic                 r_s2_v;
    logic [W-1:0]         r_out_data;
    logic                 r_out_ovf;
    logic [CNT_W-1:0]     r_ovf_count;

    // Dropping the low D bits of a two's complement word is a floor shift.
    assign w_q = i_in_data[IW-1:D];
    assign w_r = i_in_data[RW-1:0];

    fp_round_incr #(.D(D)) u_round_incr (
        .i_q_lsb (w_q[0]),
        .i_r     (w_r),
        .i_sign  (i_in_data[IW-1]),
        .i_mode  (i_mode),
        .o_inc   (w_inc)
    );

    assign w_sum = {w_q[QW-1], w_q} + {{(SW-1){1'b0}}, w_inc};

    // S2 can take a new sample when it is empty or being drained this cycle.
    assign w_s2_free  = !r_s2_v || i_out_ready;
    assign o_in_ready = !i_rst && (!r_s1_v || w_s2_free);

    // Range check on the S1 sum and selection of the output word.
    always_comb begin
        w_ovf = (r_s1_sum > MAX_V) || (r_s1_sum < MIN_V);
        w_res = r_s1_sum[W-1:0];
`ifdef FP_REQUANT_SAT_EN
        if (w_ovf) begin
            if (r_s1_sum[SW-1]) begin
                w_res = MIN_V[W-1:0];
            end else begin
                w_res = MAX_V[W-1:0];
            end
        end else begin
            w_res = r_s1_sum[W-1:0];
        end
`endif
    end

    // Stage S1: capture the rounded full-width sum of an accepted input.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_v   <= 1'b0;
            r_s1_sum <= {SW{1'b0}};
        end else if (o_in_ready) begin
            r_s1_v <= i_in_valid;
            if (i_in_valid) begin
                r_s1_sum <= w_sum;
            end
        end
    end

    // Stage S2: registered output word and overflow flag; holds while stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_v     <= 1'b0;
            r_out_data <= {W{1'b0}};
            r_out_ovf  <= 1'b0;
        end else if (w_s2_free) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_out_data <= w_res;
                r_out_ovf  <= w_ovf;
            end
        end
    end

    // Sticky overflow counter, counts overflowed output transfers, saturates.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf_count <= {CNT_W{1'b0}};
        end else if (r_s2_v && i_out_ready && r_out_ovf &&
                     (r_ovf_count != {CNT_W{1'b1}})) begin
            r_ovf_count <= r_ovf_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_out_valid = r_s2_v;
    assign o_out_data  = r_out_data;
    assign o_out_ovf   = r_out_ovf;
    assign o_ovf_count = r_ovf_count;

endmodule
